// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: register file / scoreboard bus bundle.
//   master drives read addresses, writeback and issue requests, flush.
//   slave returns read data, busy flags, iss_ready, pend_total and wb_err.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int PEND_W = 2
);
   logic [ADDR_W-1:0]        ra, rb, rw, iss_rd;
   logic [DATA_W-1:0]        bus_a, bus_b, bus_w;
   logic                     busy_a, busy_b, we, iss_valid, iss_ready, flush, wb_err;
   logic [ADDR_W+PEND_W-1:0] pend_total;
   modport master (
      output ra, rb, we, rw, bus_w, iss_valid, iss_rd, flush,
      input  bus_a, bus_b, busy_a, busy_b, iss_ready, pend_total, wb_err
   );
   modport slave (
      input  ra, rb, we, rw, bus_w, iss_valid, iss_rd, flush,
      output bus_a, bus_b, busy_a, busy_b, iss_ready, pend_total, wb_err
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with per-register pending-write scoreboard.
//   clk, reset : clock and synchronous active-high reset
//   rf (slave) : read ports ra/rb -> bus_a/bus_b + busy_a/busy_b, writeback we/rw/bus_w,
//                issue iss_valid/iss_rd -> iss_ready, flush, pend_total, sticky wb_err
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   parameter int PEND_W   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_scoreboard_if.slave  rf
);
   localparam int              DEPTH = 2**ADDR_W;
   localparam bit              BP    = BYPASS != 0;
   localparam bit              ZR    = ZERO_REG != 0;
   localparam logic [PEND_W-1:0] PMAX = '1;
   logic [DATA_W-1:0] rf_q [DEPTH];
   logic [DATA_W-1:0] rf_d [DEPTH];
   logic [PEND_W-1:0] pend_q [DEPTH];
   logic [PEND_W-1:0] pend_d [DEPTH];
   logic              wb_err_q, wb_err_d;
   logic              z_w, wb_hit, iss_cnt;
   logic [ADDR_W+PEND_W-1:0] total;
   // z_w: writeback targets the hardwired zero register and is ignored entirely
   assign z_w     = ZR && rf.rw == '0;
   assign wb_hit  = rf.we && pend_q[rf.rw] != '0 && !z_w;
   // issues to a hardwired r0 are accepted but never tracked
   assign iss_cnt = rf.iss_ready && !(ZR && rf.iss_rd == '0);
   assign rf.bus_a = (ZR && rf.ra == '0) ? '0 :
                     (BP && rf.we && !z_w && rf.rw == rf.ra) ? rf.bus_w : rf_q[rf.ra];
   assign rf.bus_b = (ZR && rf.rb == '0) ? '0 :
                     (BP && rf.we && !z_w && rf.rw == rf.rb) ? rf.bus_w : rf_q[rf.rb];
   // with bypass, the retire happening this cycle already counts as done
   assign rf.busy_a = !(ZR && rf.ra == '0) &&
                      pend_q[rf.ra] != PEND_W'(BP && wb_hit && rf.rw == rf.ra);
   assign rf.busy_b = !(ZR && rf.rb == '0) &&
                      pend_q[rf.rb] != PEND_W'(BP && wb_hit && rf.rw == rf.rb);
   // a saturated counter can still take an issue when a retire frees a slot this cycle
   assign rf.iss_ready = rf.iss_valid && !rf.flush &&
                         ((ZR && rf.iss_rd == '0) || pend_q[rf.iss_rd] != PMAX ||
                          (wb_hit && rf.rw == rf.iss_rd));
   assign rf.pend_total = total;
   assign rf.wb_err     = wb_err_q;
   always_comb begin
      rf_d     = rf_q;
      pend_d   = pend_q;
      total    = '0;
      wb_err_d = wb_err_q | (rf.we && !rf.flush && pend_q[rf.rw] == '0 && !z_w);
      if (rf.we && !z_w) rf_d[rf.rw] = rf.bus_w;
      for (int r = 0; r < DEPTH; r++) begin
         pend_d[r] = rf.flush ? '0 :
                     pend_q[r] + PEND_W'(iss_cnt && rf.iss_rd == ADDR_W'(r))
                               - PEND_W'(wb_hit && rf.rw == ADDR_W'(r));
         total     = total + (ADDR_W+PEND_W)'(pend_q[r]);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_q     <= '{default: '0};
         pend_q   <= '{default: '0};
         wb_err_q <= 1'b0;
      end else begin
         rf_q     <= rf_d;
         pend_q   <= pend_d;
         wb_err_q <= wb_err_d;
      end
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: checks a BYPASS=1 and a BYPASS=0 instance, driven identically,
//   against an array/integer model of the register file and pending counts.
module tb_regfile_scoreboard;
   localparam int PMAX = 3;
   logic        clk = 0, reset = 0;
   logic [4:0]  ra = 0, rb = 0, rw = 0, iss_rd = 0;
   logic [31:0] bus_w = 0;
   logic        we = 0, iss_valid = 0, flush = 0;
   int          checks = 0, errors = 0;
   int          rf_m [32];
   int          pend_m [32];
   bit          err_m;
   always #5 clk = ~clk;
   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) i1 ();
   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) i0 ();
   assign i1.ra = ra;  assign i1.rb = rb;  assign i1.rw = rw;  assign i1.iss_rd = iss_rd;
   assign i1.bus_w = bus_w;  assign i1.we = we;  assign i1.iss_valid = iss_valid;  assign i1.flush = flush;
   assign i0.ra = ra;  assign i0.rb = rb;  assign i0.rw = rw;  assign i0.iss_rd = iss_rd;
   assign i0.bus_w = bus_w;  assign i0.we = we;  assign i0.iss_valid = iss_valid;  assign i0.flush = flush;
   regfile_scoreboard #(.BYPASS(1)) u1 (.clk(clk), .reset(reset), .rf(i1.slave));
   regfile_scoreboard #(.BYPASS(0)) u0 (.clk(clk), .reset(reset), .rf(i0.slave));
   function automatic bit hit_m();
      return we && rw != 0 && pend_m[rw] > 0;
   endfunction
   function automatic logic [31:0] exp_bus(input logic [4:0] a, input bit bp);
      if (a == 0) return 0;
      if (bp && we && rw == a) return bus_w;
      return rf_m[a];
   endfunction
   function automatic logic exp_busy(input logic [4:0] a, input bit bp);
      return a != 0 && (pend_m[a] - ((bp && hit_m() && rw == a) ? 1 : 0)) != 0;
   endfunction
   function automatic logic exp_ready();
      return iss_valid && !flush && (iss_rd == 0 || pend_m[iss_rd] < PMAX || (hit_m() && rw == iss_rd));
   endfunction
   function automatic logic [31:0] exp_total();
      int s = 0;
      foreach (pend_m[i]) s += pend_m[i];
      return s;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask
   task automatic check_all();
      chk("bp1.bus_a", i1.bus_a, exp_bus(ra, 1));
      chk("bp1.bus_b", i1.bus_b, exp_bus(rb, 1));
      chk("bp1.busy_a", 32'(i1.busy_a), 32'(exp_busy(ra, 1)));
      chk("bp1.busy_b", 32'(i1.busy_b), 32'(exp_busy(rb, 1)));
      chk("bp1.iss_ready", 32'(i1.iss_ready), 32'(exp_ready()));
      chk("bp1.pend_total", 32'(i1.pend_total), exp_total());
      chk("bp1.wb_err", 32'(i1.wb_err), 32'(err_m));
      chk("bp0.bus_a", i0.bus_a, exp_bus(ra, 0));
      chk("bp0.bus_b", i0.bus_b, exp_bus(rb, 0));
      chk("bp0.busy_a", 32'(i0.busy_a), 32'(exp_busy(ra, 0)));
      chk("bp0.busy_b", 32'(i0.busy_b), 32'(exp_busy(rb, 0)));
      chk("bp0.iss_ready", 32'(i0.iss_ready), 32'(exp_ready()));
      chk("bp0.pend_total", 32'(i0.pend_total), exp_total());
      chk("bp0.wb_err", 32'(i0.wb_err), 32'(err_m));
   endtask
   task automatic update_model();
      bit h = hit_m();
      bit rdy = exp_ready();
      if (reset) begin
         foreach (rf_m[i]) begin rf_m[i] = 0; pend_m[i] = 0; end
         err_m = 0;
         return;
      end
      if (we && !flush && rw != 0 && pend_m[rw] == 0) err_m = 1;
      if (we && rw != 0) rf_m[rw] = bus_w;
      if (flush) foreach (pend_m[i]) pend_m[i] = 0;
      else begin
         if (rdy && iss_rd != 0) pend_m[iss_rd]++;
         if (h) pend_m[rw]--;
      end
   endtask
   task automatic step(input bit do_chk = 1);
      #2;
      if (do_chk) check_all();
      @(posedge clk);
      update_model();
      #1;
   endtask
   task automatic idle();
      reset = 0; we = 0; iss_valid = 0; flush = 0;
   endtask
   task automatic issue(input logic [4:0] d);
      idle(); iss_valid = 1; iss_rd = d; step();
   endtask
   task automatic retire(input logic [4:0] a, input logic [31:0] d);
      idle(); we = 1; rw = a; bus_w = d; step();
   endtask
   initial begin
      reset = 1; step(0);
      we = 1; rw = 3; bus_w = 32'hDEAD; ra = 3; rb = 0; step();
      idle(); step();
      issue(5); issue(5);
      ra = 5; idle(); step();
      retire(5, 32'h1234);
      retire(5, 32'h5678);
      idle(); step();
      issue(7); issue(7); issue(7);
      ra = 7; issue(7);
      idle(); iss_valid = 1; iss_rd = 7; we = 1; rw = 7; bus_w = 32'h77; step();
      retire(7, 1); retire(7, 2); retire(7, 3);
      ra = 0; rb = 7;
      idle(); we = 1; rw = 0; bus_w = 32'hFFFF_FFFF; iss_valid = 1; iss_rd = 0; step();
      idle(); step();
      issue(2); issue(9); issue(9);
      idle(); flush = 1; iss_valid = 1; iss_rd = 4; ra = 9; rb = 2; step();
      idle(); step();
      retire(9, 32'h9999);
      idle(); step();
      ra = 6; rb = 6; retire(6, 32'hA5A5);
      idle(); step();
      for (int n = 0; n < 600; n++) begin
         reset     = ($urandom_range(0, 127) == 0);
         flush     = ($urandom_range(0, 31) == 0);
         we        = $urandom_range(0, 1);
         iss_valid = $urandom_range(0, 2) != 0;
         ra        = 5'($urandom_range(0, 7));
         rb        = 5'($urandom_range(0, 7));
         rw        = 5'($urandom_range(0, 7));
         iss_rd    = 5'($urandom_range(0, 7));
         bus_w     = $urandom;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised pipeline register file with 2 asynchronous read ports, 1 synchronous write port, configurable write-through bypass and an integrated per-register pending-write scoreboard. Decode issues destination registers and reads busy flags to generate stalls. Writeback retires pending writes. Flush clears the scoreboard on control-hazard squash.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; depth = 2**ADDR_W
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = array value only
ZERO_REG, 1, 1 = register 0 hardwired zero, never busy
PEND_W, 2, width of per-register pending-write counter (max 2**PEND_W-1 outstanding)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
ra  in  ADDR_W  read address A
rb  in  ADDR_W  read address B
bus_a  out  DATA_W  read data A
bus_b  out  DATA_W  read data B
busy_a  out  1  register ra has unretired writes
busy_b  out  1  register rb has unretired writes
we  in  1  writeback strobe
rw  in  ADDR_W  writeback address
bus_w  in  DATA_W  writeback data
iss_valid  in  1  issue request: instruction writing iss_rd enters pipe
iss_rd  in  ADDR_W  issued destination
iss_ready  out  1  issue accepted this cycle
flush  in  1  clear all pending counters
pend_total  out  ADDR_W+PEND_W  sum of all pending counters
wb_err  out  1  sticky: writeback retired a register with zero pending

Behaviour:
- Reset (clk edge with reset=1): all registers, counters and wb_err cleared to 0. Reset overrides we, iss_valid and flush. After reset: bus_a=bus_b=0, busy_a=busy_b=0, iss_ready=1 (while iss_valid), pend_total=0.
- Write: on clk edge, if we and !(ZERO_REG && rw==0), RF[rw] <= bus_w. Writes to r0 are dropped when ZERO_REG=1.
- Read (combinational, 0 latency):
  - bus_a = 0 if ZERO_REG && ra==0.
  - else bus_w if BYPASS && we && rw==ra (rw!=0 when ZERO_REG).
  - else RF[ra].
  - bus_b identical on rb.
- Retire qualifier: wb_hit = we && pend[rw]!=0 && !(ZERO_REG && rw==0).
- Busy:
  - busy_a = (pend[ra] - (BYPASS && wb_hit && rw==ra)) != 0, forced 0 when ZERO_REG && ra==0.
  - With BYPASS=0 the same-cycle retire does not clear busy.
  - busy_b identical on rb.
  - Busy never reflects same-cycle issue.
- Issue:
  - iss_ready = iss_valid && (ZERO_REG && iss_rd==0 || pend[iss_rd] != max || wb_hit && rw==iss_rd) && !flush.
  - Issue to r0 (ZERO_REG) is accepted but not counted.
- Counter update per register r (clk edge, reset=0):
  - flush=1: all pend <= 0 (same-cycle issue and retire ignored for counting; write data still written).
  - else inc = iss_ready && iss_rd==r (and counted); dec = wb_hit && rw==r.
  - pend[r] <= pend[r] + inc - dec. Simultaneous inc and dec on same r leaves it unchanged.
  - Counters never wrap: inc blocked at max by iss_ready; dec blocked at 0 by wb_hit.
- wb_err: set on clk edge when we && !flush && pend[rw]==0 && !(ZERO_REG && rw==0). Cleared only by reset. The write still occurs.
- pend_total: combinational sum of all pend[].

Test Plan:
- Reset then read: reset=1 one cycle with we=1,rw=3,bus_w=32'hDEAD -> RF[3] stays 0; bus_a(ra=3)=0, busy_a=0, pend_total=0, wb_err=0.
- Issue/retire: issue r5 twice over two cycles -> pend_total=2, busy_a(ra=5)=1. Then we=1,rw=5,bus_w=32'h1234 -> busy_a stays 1 and bus_a=32'h1234 same cycle. Second retire cycle -> busy_a=0 combinationally (BYPASS=1), pend_total=0 next cycle.
- Saturation: issue r7 three times -> pend[7]=3, next iss_valid to r7 gives iss_ready=0. Same cycle with we,rw=7 -> iss_ready=1 and pend stays 3.
- Zero reg: we=1,rw=0,bus_w=32'hFFFF_FFFF; iss_valid,iss_rd=0 -> bus_a(ra=0)=0, busy_a=0, iss_ready=1, pend_total unchanged, wb_err unchanged.
- Flush: pend[2]=1,pend[9]=2, then flush with iss_valid,iss_rd=4 -> iss_ready=0, pend_total=0 next cycle. Subsequent we,rw=9 writes RF[9] and sets wb_err=1.
- BYPASS=0 build: we,rw=6,bus_w=32'hA5A5 with ra=6 -> bus_a shows old RF[6] that cycle, 32'hA5A5 next cycle.
